// File: rtl/river_ride_ctrl.sv
// River-band fate controller for the frog: tracks which lilypad (if any) is
// carrying the frog, produces the per-frame carry delta, and runs the
// grace / death / respawn / game-over sequence.
//
// Protocol note: there is no valid/ready handshake here. Every input is
// sampled once per frame on the rising edge of frame_clk, and every output
// is a registered value that holds for the whole following frame.
module river_ride_ctrl #(
  parameter int          NUM_PADS     = 4,
  parameter logic [10:0] RIVER_Y_MIN  = 11'd40,
  parameter logic [10:0] RIVER_Y_MAX  = 11'd240,
  parameter logic [10:0] X_EDGE_MAX   = 11'd600,
  parameter logic [10:0] MAX_STEP     = 11'd16,
  parameter logic [4:0]  GRACE_FRAMES = 5'd3,
  parameter logic [5:0]  DEATH_FRAMES = 6'd30,
  parameter logic [2:0]  START_LIVES  = 3'd3
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [10:0]              Frog_X,
  input  logic [10:0]              Frog_Y,
  input  logic [11*NUM_PADS-1:0]   Pad_X,
  input  logic [NUM_PADS-1:0]      Pad_Collision,
  output logic [10:0]              Carry_DX,
  output logic                     Riding,
  output logic                     Death_Active,
  output logic                     Respawn,
  output logic [2:0]               Lives,
  output logic                     Game_Over,
  output logic [2:0]               dbg_state_o
);

  localparam int IDXW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  typedef enum logic [2:0] {
    ST_LAND   = 3'd0,
    ST_RIDING = 3'd1,
    ST_GRACE  = 3'd2,
    ST_DYING  = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            pad_idx_q, pad_idx_d;
  logic [4:0]                 grace_q, grace_d;
  logic [5:0]                 death_q, death_d;
  logic [2:0]                 lives_q, lives_d;
  logic                       respawn_q, respawn_d;
  logic [10:0]                carry_q, carry_d;
  logic                       delta_valid_q;
  logic [10:0]                prev_x_q [NUM_PADS];

  logic [10:0]                pad_x [NUM_PADS];
  logic                       in_river;
  logic                       hit;
  logic [IDXW-1:0]            first_hit;
  logic [10:0]                delta;
  logic [10:0]                delta_mag;
  logic                       delta_ok;

  // Unpack the pad bus and derive river membership plus the lowest colliding pad.
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_x[i] = Pad_X[11*i +: 11];
    end
    in_river  = (Frog_Y >= RIVER_Y_MIN) && (Frog_Y < RIVER_Y_MAX);
    hit       = |Pad_Collision;
    first_hit = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (Pad_Collision[i]) first_hit = IDXW'(i);
    end
  end

  // Next state, pad selection, counters and lives.
  always_comb begin
    state_d   = state_q;
    pad_idx_d = pad_idx_q;
    grace_d   = grace_q;
    death_d   = death_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    case (state_q)
      ST_LAND: begin
        if (in_river) begin
          if (hit) begin
            state_d   = ST_RIDING;
            pad_idx_d = first_hit;
          end else begin
            state_d = ST_GRACE;
            grace_d = '0;
          end
        end
      end
      ST_RIDING: begin
        if (!in_river) begin
          state_d = ST_LAND;
        end else if (Frog_X > X_EDGE_MAX) begin
          // Unsigned compare also catches a frog pushed past the left edge (wrap).
          state_d = ST_DYING;
          death_d = '0;
        end else if (!Pad_Collision[pad_idx_q]) begin
          if (hit) begin
            pad_idx_d = first_hit;
          end else begin
            state_d = ST_GRACE;
            grace_d = '0;
          end
        end
      end
      ST_GRACE: begin
        if (!in_river) begin
          state_d = ST_LAND;
        end else if (hit) begin
          state_d   = ST_RIDING;
          pad_idx_d = first_hit;
        end else begin
          grace_d = grace_q + 5'd1;
          if (grace_d == GRACE_FRAMES - 5'd1) begin
            state_d = ST_DYING;
            death_d = '0;
          end
        end
      end
      ST_DYING: begin
        if (death_q == DEATH_FRAMES - 6'd1) begin
          death_d = '0;
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          if (lives_d == 3'd0) begin
            state_d = ST_DEAD;
          end else begin
            state_d   = ST_LAND;
            respawn_d = 1'b1;
          end
        end else begin
          death_d = death_q + 6'd1;
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_LAND;
      end
    endcase
  end

  // Carry delta of the pad that carries the frog next frame; teleports and
  // the first post-reset frame are suppressed to zero.
  always_comb begin
    delta     = pad_x[pad_idx_d] - prev_x_q[pad_idx_d];
    delta_mag = delta[10] ? (~delta + 11'd1) : delta;
    delta_ok  = delta_valid_q && (delta_mag <= MAX_STEP);
    carry_d   = ((state_d == ST_RIDING) && delta_ok) ? delta : 11'd0;
  end

  // State, counters, lives and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_LAND;
      pad_idx_q     <= '0;
      grace_q       <= '0;
      death_q       <= '0;
      lives_q       <= START_LIVES;
      respawn_q     <= 1'b0;
      carry_q       <= '0;
      delta_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pad_idx_q     <= pad_idx_d;
      grace_q       <= grace_d;
      death_q       <= death_d;
      lives_q       <= lives_d;
      respawn_q     <= respawn_d;
      carry_q       <= carry_d;
      delta_valid_q <= 1'b1;
    end
  end

  // Previous-frame pad positions used for the delta.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PADS; i++) prev_x_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) prev_x_q[i] <= pad_x[i];
    end
  end

  assign Carry_DX     = carry_q;
  assign Riding       = (state_q == ST_RIDING);
  assign Death_Active = (state_q == ST_DYING);
  assign Respawn      = respawn_q;
  assign Lives        = lives_q;
  assign Game_Over    = (state_q == ST_DEAD);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_river_ride_ctrl.sv
// Directed bench for river_ride_ctrl: riding, wrap suppression, pad hand-off,
// grace pickup, drowning, edge death, game over and reset recovery.
module tb_river_ride_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [10:0] Frog_X;
  logic [10:0] Frog_Y;
  logic [43:0] Pad_X;
  logic [3:0]  Pad_Collision;
  logic [10:0] Carry_DX;
  logic        Riding;
  logic        Death_Active;
  logic        Respawn;
  logic [2:0]  Lives;
  logic        Game_Over;
  logic [2:0]  dbg_state_o;

  logic [10:0] pad_x [4];
  int          n_vec;
  int          n_err;

  localparam logic [2:0] S_LAND   = 3'd0;
  localparam logic [2:0] S_RIDING = 3'd1;
  localparam logic [2:0] S_GRACE  = 3'd2;
  localparam logic [2:0] S_DYING  = 3'd3;
  localparam logic [2:0] S_DEAD   = 3'd4;

  assign Pad_X = {pad_x[3], pad_x[2], pad_x[1], pad_x[0]};

  river_ride_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .Frog_X        (Frog_X),
    .Frog_Y        (Frog_Y),
    .Pad_X         (Pad_X),
    .Pad_Collision (Pad_Collision),
    .Carry_DX      (Carry_DX),
    .Riding        (Riding),
    .Death_Active  (Death_Active),
    .Respawn       (Respawn),
    .Lives         (Lives),
    .Game_Over     (Game_Over),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock: 10 time-unit frame period.
  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run the remaining 29 frames of a death animation, then check the exit frame.
  task automatic finish_death(input logic [2:0] exp_lives, input logic exp_resp,
                              input logic [2:0] exp_state);
    for (int i = 0; i < 29; i++) begin
      frame();
      chk("death_hold", {31'd0, Death_Active}, 32'd1);
      chk("death_no_respawn", {31'd0, Respawn}, 32'd0);
    end
    frame();
    chk("death_end_active", {31'd0, Death_Active}, 32'd0);
    chk("death_end_lives", {29'd0, Lives}, {29'd0, exp_lives});
    chk("death_end_respawn", {31'd0, Respawn}, {31'd0, exp_resp});
    chk("death_end_state", {29'd0, dbg_state_o}, {29'd0, exp_state});
    chk("death_end_gameover", {31'd0, Game_Over}, {31'd0, exp_state == S_DEAD});
    frame();
    chk("respawn_one_frame", {31'd0, Respawn}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    Frog_X = 11'd100;
    Frog_Y = 11'd300;
    Pad_Collision = 4'b0000;
    for (int i = 0; i < 4; i++) pad_x[i] = 11'd300;
    #12;
    chk("rst_carry", {21'd0, Carry_DX}, 32'd0);
    chk("rst_riding", {31'd0, Riding}, 32'd0);
    chk("rst_death", {31'd0, Death_Active}, 32'd0);
    chk("rst_respawn", {31'd0, Respawn}, 32'd0);
    chk("rst_lives", {29'd0, Lives}, 32'd3);
    chk("rst_gameover", {31'd0, Game_Over}, 32'd0);
    chk("rst_state", {29'd0, dbg_state_o}, {29'd0, S_LAND});
    Reset = 1'b0;

    // Board pad0 and ride it leftwards at 10 px/frame.
    Frog_Y = 11'd100; Pad_Collision = 4'b0001; pad_x[0] = 11'd200;
    frame();
    chk("board_state", {29'd0, dbg_state_o}, {29'd0, S_RIDING});
    chk("board_riding", {31'd0, Riding}, 32'd1);
    chk("board_carry", {21'd0, Carry_DX}, 32'd0);
    pad_x[0] = 11'd190; frame();
    chk("ride_carry1", {21'd0, Carry_DX}, 32'h7F6);
    pad_x[0] = 11'd180; frame();
    chk("ride_carry2", {21'd0, Carry_DX}, 32'h7F6);

    // Screen-wrap jumps are suppressed, normal motion resumes afterwards.
    pad_x[0] = 11'd0; frame();
    chk("wrap_big_step", {21'd0, Carry_DX}, 32'd0);
    pad_x[0] = 11'd640; frame();
    chk("wrap_jump", {21'd0, Carry_DX}, 32'd0);
    pad_x[0] = 11'd630; frame();
    chk("wrap_resume", {21'd0, Carry_DX}, 32'h7F6);

    // Lose pad0 while pad1/pad2 collide: hand off to pad1 (lowest index).
    Pad_Collision = 4'b0110; pad_x[0] = 11'd620; pad_x[1] = 11'd305;
    frame();
    chk("handoff_carry", {21'd0, Carry_DX}, 32'd5);
    chk("handoff_riding", {31'd0, Riding}, 32'd1);

    // Two frames of open water then pad2: rescued, no death.
    Pad_Collision = 4'b0000; frame();
    chk("grace1_state", {29'd0, dbg_state_o}, {29'd0, S_GRACE});
    chk("grace1_riding", {31'd0, Riding}, 32'd0);
    chk("grace1_carry", {21'd0, Carry_DX}, 32'd0);
    frame();
    chk("grace2_state", {29'd0, dbg_state_o}, {29'd0, S_GRACE});
    chk("grace2_death", {31'd0, Death_Active}, 32'd0);
    Pad_Collision = 4'b0100; frame();
    chk("rescue_state", {29'd0, dbg_state_o}, {29'd0, S_RIDING});
    pad_x[2] = 11'd310; pad_x[0] = 11'd610; frame();
    chk("rescue_pad2_carry", {21'd0, Carry_DX}, 32'h00A);
    chk("rescue_lives", {29'd0, Lives}, 32'd3);

    // Leaving the river (Y=240 is outside) beats the edge check.
    Frog_Y = 11'd240; Frog_X = 11'd605; frame();
    chk("prio_state", {29'd0, dbg_state_o}, {29'd0, S_LAND});
    chk("prio_death", {31'd0, Death_Active}, 32'd0);

    // Drown: three frames without a pad at the top river row.
    Frog_X = 11'd100; Frog_Y = 11'd40; Pad_Collision = 4'b0000;
    frame();
    chk("drown1_state", {29'd0, dbg_state_o}, {29'd0, S_GRACE});
    frame();
    chk("drown2_death", {31'd0, Death_Active}, 32'd0);
    frame();
    chk("drown3_death", {31'd0, Death_Active}, 32'd1);
    chk("drown3_carry", {21'd0, Carry_DX}, 32'd0);
    Frog_Y = 11'd300;
    finish_death(3'd2, 1'b1, S_LAND);

    // Edge deaths until game over.
    for (int life = 2; life >= 1; life--) begin
      Frog_Y = 11'd100; Frog_X = 11'd100; Pad_Collision = 4'b0001;
      frame();
      chk("edge_board", {29'd0, dbg_state_o}, {29'd0, S_RIDING});
      Frog_X = 11'd605; frame();
      chk("edge_dying", {29'd0, dbg_state_o}, {29'd0, S_DYING});
      chk("edge_carry", {21'd0, Carry_DX}, 32'd0);
      Frog_Y = 11'd300; Frog_X = 11'd100;
      finish_death(3'(life - 1), (life > 1), (life > 1) ? S_LAND : S_DEAD);
    end

    // Dead: inputs ignored.
    Frog_Y = 11'd100; Pad_Collision = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("dead_state", {29'd0, dbg_state_o}, {29'd0, S_DEAD});
      chk("dead_gameover", {31'd0, Game_Over}, 32'd1);
      chk("dead_riding", {31'd0, Riding}, 32'd0);
      chk("dead_lives", {29'd0, Lives}, 32'd0);
    end

    // Reset restores lives.
    Reset = 1'b1; Pad_Collision = 4'b0000; #1;
    chk("rst2_lives", {29'd0, Lives}, 32'd3);
    chk("rst2_gameover", {31'd0, Game_Over}, 32'd0);
    chk("rst2_state", {29'd0, dbg_state_o}, {29'd0, S_LAND});
    #1 Reset = 1'b0;

    // Lose one life, then reset in the middle of the next death.
    frame(); frame(); frame();
    chk("drownb_death", {31'd0, Death_Active}, 32'd1);
    Frog_Y = 11'd300;
    finish_death(3'd2, 1'b1, S_LAND);
    Frog_Y = 11'd100;
    frame(); frame(); frame();
    chk("drownc_death", {31'd0, Death_Active}, 32'd1);
    for (int i = 0; i < 12; i++) frame();
    chk("mid_death_active", {31'd0, Death_Active}, 32'd1);
    chk("mid_death_lives", {29'd0, Lives}, 32'd2);
    Reset = 1'b1; #1;
    chk("rst3_death", {31'd0, Death_Active}, 32'd0);
    chk("rst3_lives", {29'd0, Lives}, 32'd3);
    chk("rst3_state", {29'd0, dbg_state_o}, {29'd0, S_LAND});
    chk("rst3_carry", {21'd0, Carry_DX}, 32'd0);
    chk("rst3_respawn", {31'd0, Respawn}, 32'd0);
    #1 Reset = 1'b0;

    // First post-reset frame: small delta from cleared history still ignored.
    pad_x[0] = 11'd5; Pad_Collision = 4'b0001; frame();
    chk("post_rst_state", {29'd0, dbg_state_o}, {29'd0, S_RIDING});
    chk("post_rst_carry", {21'd0, Carry_DX}, 32'd0);
    pad_x[0] = 11'd8; frame();
    chk("post_rst_carry2", {21'd0, Carry_DX}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
